pll_lock_reset_ctrl: RTL and testbench

Consumer side of the coprocessor PLL's reset/locked interface. It runs on the free-running 50 MHz reference clock. It drives the PLL reset, watches the PLL locked output, and retries when lock never arrives. It releases the system reset for the 75 MHz coprocessor domain only after lock has been continuously stable; the 75 MHz domain re-synchronises that reset locally.

---
 rtl/clk_rst_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/pll_lock_reset_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pll_lock_reset_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// State encoding and default parameters shared by the PLL lock/reset controller.
// FAIL is only reachable when PLL_RETRY_LIMIT_EN is defined.
package clk_rst_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_e;

   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 50000;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 4;
   localparam int DEF_CNT_W         = 8;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, one independent chain per bit.
// Asynchronous active-low reset clears both stages to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
         end else begin
            meta_reg <= d[gi];
            sync_reg <= meta_reg;
         end
      end

      assign q[gi] = sync_reg;
   end

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a continuously stable lock, then releases
// the coprocessor reset. Define PLL_RETRY_LIMIT_EN to park in FAIL after MAX_RETRIES timeouts.
module pll_lock_reset_ctrl
   import clk_rst_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             locked,
   input  logic             sw_relock,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic             fail
);

   localparam int RST_W = cnt_width(RST_CYCLES);
   localparam int TMO_W = cnt_width(LOCK_TIMEOUT);
   localparam int STB_W = cnt_width(STABLE_CYCLES);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOSS_MAX = '1;

   // Parameter sanity hook; an illegal set elaborates this empty block for easy spotting.
   if (RST_CYCLES < 2 || STABLE_CYCLES < 2 || LOCK_TIMEOUT < 1 || MAX_RETRIES < 1 || CNT_W < 1)
   begin : g_bad_params
   end

   logic locked_s;

   sync_2ff #(.WIDTH(1)) u_locked_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   pll_state_e       state_reg, state_next;
   logic [RST_W-1:0] rst_cnt_reg, rst_cnt_next;
   logic [TMO_W-1:0] timer_reg, timer_next;
   logic [STB_W-1:0] stable_cnt_reg, stable_cnt_next;
   logic [CNT_W-1:0] loss_cnt_reg, loss_cnt_next;
   logic             pll_rst_reg;
   logic             run_reg;

`ifdef PLL_RETRY_LIMIT_EN
   localparam int RTY_W = cnt_width(MAX_RETRIES);
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

   logic [RTY_W-1:0] retry_cnt_reg, retry_cnt_next;
   logic             fail_reg;
`endif

   always_comb begin
      state_next      = state_reg;
      rst_cnt_next    = '0;
      timer_next      = '0;
      stable_cnt_next = '0;
      loss_cnt_next   = loss_cnt_reg;
`ifdef PLL_RETRY_LIMIT_EN
      retry_cnt_next  = retry_cnt_reg;
`endif
      case (state_reg)
         PLL_RST: begin
            // A relock request during the pulse is dropped; the pulse never restarts.
            if (rst_cnt_reg == RST_LAST) state_next = WAIT_LOCK;
            else                         rst_cnt_next = rst_cnt_reg + 1'b1;
         end
         WAIT_LOCK: begin
            if (sw_relock)     state_next = PLL_RST;
            else if (locked_s) state_next = STABLE;
            else if (timer_reg == TMO_LAST) begin
`ifdef PLL_RETRY_LIMIT_EN
               if (retry_cnt_reg == RTY_LAST) begin
                  state_next = FAIL;
               end else begin
                  state_next     = PLL_RST;
                  retry_cnt_next = retry_cnt_reg + 1'b1;
               end
`else
               state_next = PLL_RST;
`endif
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         STABLE: begin
            if (sw_relock)      state_next = PLL_RST;
            else if (!locked_s) state_next = WAIT_LOCK;
            else if (stable_cnt_reg == STB_LAST) begin
               state_next = RUN;
`ifdef PLL_RETRY_LIMIT_EN
               retry_cnt_next = '0;
`endif
            end else begin
               stable_cnt_next = stable_cnt_reg + 1'b1;
            end
         end
         RUN: begin
            // Loss takes precedence so a coincident relock request still counts the loss.
            if (!locked_s) begin
               state_next = PLL_RST;
               if (loss_cnt_reg != LOSS_MAX) loss_cnt_next = loss_cnt_reg + 1'b1;
            end else if (sw_relock) begin
               state_next = PLL_RST;
            end
         end
`ifdef PLL_RETRY_LIMIT_EN
         FAIL: state_next = FAIL;
`endif
         default: state_next = PLL_RST;
      endcase
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= PLL_RST;
         rst_cnt_reg    <= '0;
         timer_reg      <= '0;
         stable_cnt_reg <= '0;
         loss_cnt_reg   <= '0;
         pll_rst_reg    <= 1'b1;
         run_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rst_cnt_reg    <= rst_cnt_next;
         timer_reg      <= timer_next;
         stable_cnt_reg <= stable_cnt_next;
         loss_cnt_reg   <= loss_cnt_next;
         pll_rst_reg    <= (state_next == PLL_RST) || (state_next == FAIL);
         run_reg        <= (state_next == RUN);
      end
   end

`ifdef PLL_RETRY_LIMIT_EN
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt_reg <= '0;
         fail_reg      <= 1'b0;
      end else begin
         retry_cnt_reg <= retry_cnt_next;
         fail_reg      <= (state_next == FAIL);
      end
   end

   assign fail = fail_reg;
`else
   assign fail = 1'b0;
`endif

   assign pll_rst       = pll_rst_reg;
   assign sys_rst_n     = run_reg;
   assign ready         = run_reg;
   assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Bench for pll_lock_reset_ctrl: vector table, directed corner sequences and a randomized
// run against a phase/age reference model. Honours PLL_RETRY_LIMIT_EN when defined.
module tb_pll_lock_reset_ctrl;

   localparam int RST_C = 4;
   localparam int TMO_C = 20;
   localparam int STB_C = 8;
   localparam int MAXR  = 2;
   localparam int CW    = 2;

`ifdef PLL_RETRY_LIMIT_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam int PH_RST    = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAIL   = 4;

   logic          refclk;
   logic          rst_n;
   logic          locked;
   logic          sw_relock;
   logic          pll_rst;
   logic          sys_rst_n;
   logic          ready;
   logic [CW-1:0] lock_loss_cnt;
   logic          fail;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic          rst_n;
      logic          locked;
      logic          sw;
      logic          e_pll;
      logic          e_run;
      logic [CW-1:0] e_loss;
      logic          e_fail;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   int         m_phase;
   int         m_age;
   int         m_losses;
   int         m_timeouts;
   logic [1:0] m_sync;

   pll_lock_reset_ctrl #(
      .RST_CYCLES    (RST_C),
      .LOCK_TIMEOUT  (TMO_C),
      .STABLE_CYCLES (STB_C),
      .MAX_RETRIES   (MAXR),
      .CNT_W         (CW)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .locked        (locked),
      .sw_relock     (sw_relock),
      .pll_rst       (pll_rst),
      .sys_rst_n     (sys_rst_n),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt),
      .fail          (fail)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s [%0d]: got %0h, required %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input int idx, input logic e_pll,
                             input logic e_run, input logic [CW-1:0] e_loss, input logic e_fail);
      check({name, " pll_rst"}, idx, 32'(pll_rst), 32'(e_pll));
      check({name, " sys_rst_n"}, idx, 32'(sys_rst_n), 32'(e_run));
      check({name, " ready"}, idx, 32'(ready), 32'(e_run));
      check({name, " lock_loss_cnt"}, idx, 32'(lock_loss_cnt), 32'(e_loss));
      check({name, " fail"}, idx, 32'(fail), 32'(e_fail));
   endtask

   function automatic void add_vec(input logic r, input logic l, input logic s, input logic p,
                                   input logic run, input logic [CW-1:0] loss, input logic f);
      vec_t v;
      v.rst_n = r; v.locked = l; v.sw = s;
      v.e_pll = p; v.e_run = run; v.e_loss = loss; v.e_fail = f;
      vecs.push_back(v);
   endfunction

   // Drive at the falling edge, return 1 time unit after the following rising edge.
   task automatic tick(input logic l, input logic s);
      @(negedge refclk);
      rst_n     = 1'b1;
      locked    = l;
      sw_relock = s;
      @(posedge refclk);
      #1;
   endtask

   task automatic run_ticks(input int n, input logic l, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         tick(l, 1'b0);
         if (pll_rst) highs++;
      end
   endtask

   task automatic do_reset();
      @(negedge refclk);
      rst_n     = 1'b0;
      sw_relock = 1'b0;
      @(posedge refclk);
      #1;
   endtask

   task automatic model_reset();
      m_phase    = PH_RST;
      m_age      = 0;
      m_losses   = 0;
      m_timeouts = 0;
      m_sync     = 2'b00;
   endtask

   // One clock edge of the reference: the FSM sees locked as it was two edges ago.
   task automatic model_step(input logic l, input logic s);
      logic ls;
      int   nxt;
      ls  = m_sync[1];
      nxt = m_phase;
      case (m_phase)
         PH_RST: if (m_age + 1 >= RST_C) nxt = PH_WAIT;
         PH_WAIT: begin
            if (s) nxt = PH_RST;
            else if (ls) nxt = PH_STABLE;
            else if (m_age + 1 >= TMO_C) begin
               m_timeouts++;
               nxt = (RETRY_EN && m_timeouts >= MAXR) ? PH_FAIL : PH_RST;
            end
         end
         PH_STABLE: begin
            if (s) nxt = PH_RST;
            else if (!ls) nxt = PH_WAIT;
            else if (m_age + 1 >= STB_C) begin
               nxt        = PH_RUN;
               m_timeouts = 0;
            end
         end
         PH_RUN: begin
            if (!ls) begin
               nxt = PH_RST;
               if (m_losses < (1 << CW) - 1) m_losses++;
            end else if (s) begin
               nxt = PH_RST;
            end
         end
         default: ;
      endcase
      m_age   = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
      m_sync  = {m_sync[0], l};
   endtask

   task automatic compare_model(input int idx);
      check_outs("rand", idx, (m_phase == PH_RST) || (m_phase == PH_FAIL), m_phase == PH_RUN,
                 CW'(m_losses), m_phase == PH_FAIL);
   endtask

   initial begin
      int   h;
      int   h2;
      int   run_left;
      logic lvl;
      logic sw;
      bit   dead;

      rst_n = 1'b1; locked = 1'b0; sw_relock = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check_outs("reset", 0, 1'b1, 1'b0, '0, 1'b0);

      // Locked held low: repeating relock attempts (or FAIL after the retry limit).
      add_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int t = 1; t <= 60; t++) begin
         dead = RETRY_EN && (t >= MAXR * (RST_C + TMO_C));
         add_vec(1'b1, 1'b0, 1'b0, dead ? 1'b1 : ((t % (RST_C + TMO_C)) < RST_C),
                 1'b0, '0, dead);
      end
      // Lock arrives 10 cycles after release; release STB_C+2 edges after first sample.
      add_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int t = 1; t <= 24; t++)
         add_vec(1'b1, t >= 10, 1'b0, t < RST_C, t >= 10 + STB_C + 2, '0, 1'b0);

      foreach (vecs[i]) begin
         @(negedge refclk);
         rst_n     = vecs[i].rst_n;
         locked    = vecs[i].locked;
         sw_relock = vecs[i].sw;
         @(posedge refclk);
         #1;
         check_outs("vec", i, vecs[i].e_pll, vecs[i].e_run, vecs[i].e_loss, vecs[i].e_fail);
      end

      // Loss and relock request seen on the same edge: one pulse, one count.
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      h = pll_rst ? 1 : 0;
      run_ticks(24, 1'b1, h2);
      check("both pulse len", 0, h + h2, 4);
      check("both loss cnt", 0, 32'(lock_loss_cnt), 1);
      check("both relocked", 0, 32'(ready), 1);

      // Relock request alone: same pulse, no count.
      tick(1'b1, 1'b1);
      h = pll_rst ? 1 : 0;
      run_ticks(24, 1'b1, h2);
      check("sw pulse len", 0, h + h2, 4);
      check("sw loss cnt", 0, 32'(lock_loss_cnt), 1);
      check("sw relocked", 0, 32'(ready), 1);

      // Glitch while the stable window is at 5: window restarts, no pulse, no count.
      tick(1'b1, 1'b1);
      h = pll_rst ? 1 : 0;
      run_ticks(8, 1'b1, h2);
      check("stable pre pulse", 0, h + h2, 4);
      tick(1'b0, 1'b0);
      run_ticks(10, 1'b1, h);
      check("stable glitch pulse", 0, h, 0);
      check("stable window restart", 0, 32'(ready), 0);
      tick(1'b1, 1'b0);
      check("stable window done", 0, 32'(ready), 1);
      check("stable loss cnt", 0, 32'(lock_loss_cnt), 1);

      // Asynchronous reset in the middle of STABLE.
      tick(1'b1, 1'b1);
      run_ticks(7, 1'b1, h);
      check_outs("mid stable", 0, 1'b0, 1'b0, 2'd1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_outs("async rst stable", 0, 1'b1, 1'b0, '0, 1'b0);

      // Four single-cycle lock drops from RUN: counter saturates at 3.
      run_ticks(14, 1'b1, h);
      check("relock pulse after rst", 0, h, RST_C - 1);
      check("relock ready", 0, 32'(ready), 1);
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0);
         run_ticks(20, 1'b1, h);
         check("drop pulse len", k, h, 4);
         check("drop loss cnt", k, 32'(lock_loss_cnt), (k < 3) ? k : 3);
         check("drop relocked", k, 32'(ready), 1);
      end

`ifdef PLL_RETRY_LIMIT_EN
      // Retry limit: FAIL ignores locked and sw_relock; only rst_n leaves it.
      locked = 1'b0;
      do_reset();
      run_ticks(50, 1'b0, h);
      check_outs("fail entered", 0, 1'b1, 1'b0, '0, 1'b1);
      tick(1'b1, 1'b1);
      run_ticks(12, 1'b1, h);
      check_outs("fail hold", 0, 1'b1, 1'b0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_outs("async rst fail", 0, 1'b1, 1'b0, '0, 1'b0);
`endif

      // Randomized run against the reference model, with occasional resets.
      do_reset();
      model_reset();
      compare_model(-1);
      run_left = 0;
      lvl      = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (run_left == 0) begin
            lvl      = ($urandom_range(0, 3) != 0);
            run_left = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
         end
         run_left--;
         sw = ($urandom_range(0, 39) == 0);
         if (c % 700 == 699) begin
            do_reset();
            model_reset();
         end else begin
            tick(lvl, sw);
            model_step(lvl, sw);
         end
         compare_model(c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
